// File: rtl/des_defs_pkg.sv
// Shared DES key-schedule constants: widths, per-round shift amounts, FSM states
// and the 28-bit C/D half rotations used between rounds.
package des_defs_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUNDS   = 16;

    // SHIFT[0] is the rotation applied before round 1
    localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_e;

    typedef logic [CD_W-1:0] half_t;

    function automatic logic shift_two(input logic [4:0] r);
        logic two;
        two = 1'b0;
        for (int unsigned i = 0; i < ROUNDS; i++) begin
            if (r == 5'(i + 1)) two = (SHIFT[4'(i)] == 2);
        end
        return two;
    endfunction

    function automatic half_t rol_half(input half_t x, input logic two);
        return two ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
    endfunction

    function automatic half_t ror_half(input half_t x, input logic two);
        return two ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
    endfunction

endpackage

// File: rtl/des_pc1.sv
// DES Permuted Choice 1: 64-bit key (bit 1 = MSB) to 56-bit C||D; parity bits dropped.
module des_pc1
    import des_defs_pkg::*;
(
    input  logic [KEY_W-1:0]  key_i,
    output logic [2*CD_W-1:0] cd_o
);

    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

    // Table entries are 1-based from the MSB; map onto the descending vectors
    always_comb begin
        cd_o = '0;
        for (int unsigned j = 0; j < 56; j++) begin
            cd_o[6'(55 - j)] = key_i[6'(KEY_W - PC1_TAB[6'(j)])];
        end
    end

endmodule

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: 56-bit C||D to the 48-bit round subkey.
module des_pc2
    import des_defs_pkg::*;
(
    input  logic [2*CD_W-1:0]   cd_i,
    output logic [SUBKEY_W-1:0] subkey_o
);

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    logic unused_drop;
    assign unused_drop = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                           cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

    always_comb begin
        subkey_o = '0;
        for (int unsigned j = 0; j < 48; j++) begin
            subkey_o[6'(47 - j)] = cd_i[6'(2 * CD_W - PC2_TAB[6'(j)])];
        end
    end

endmodule

// File: rtl/des_key_scheduler.sv
// Streams the 16 DES round subkeys one per handshake, in encrypt or decrypt order,
// rotating the C/D halves in place so no subkey storage is needed.
module des_key_scheduler
    import des_defs_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          subkey_round,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic                done
);

    state_e      state_q, state_d;
    half_t       c_q, c_d, d_q, d_d;
    logic        dec_q, dec_d;
    logic [4:0]  round_q, round_d;
    logic        done_q, done_d;
    logic        rot_two;
    logic [2*CD_W-1:0] pc1_cd;

    des_pc1 u_pc1 (
        .key_i (key_in),
        .cd_o  (pc1_cd)
    );

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey)
    );

    // Round 16 wraps to 0 in the 4-bit field; subkey_valid distinguishes it from IDLE
    assign subkey_round = round_q[3:0];
    assign done         = done_q;

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        d_d          = d_q;
        dec_d        = dec_q;
        round_d      = round_q;
        done_d       = 1'b0;
        rot_two      = 1'b0;
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                key_ready = rst_n;
                if (key_valid && rst_n) begin
                    dec_d   = decrypt;
                    round_d = 5'd1;
                    state_d = ROUND;
                    if (decrypt) begin
                        c_d = pc1_cd[2*CD_W-1:CD_W];
                        d_d = pc1_cd[CD_W-1:0];
                    end else begin
                        c_d = rol_half(pc1_cd[2*CD_W-1:CD_W], 1'b0);
                        d_d = rol_half(pc1_cd[CD_W-1:0], 1'b0);
                    end
                end
            end
            ROUND: begin
                subkey_valid = rst_n;
                if (subkey_ready) begin
                    if (round_q == 5'(ROUNDS)) begin
                        state_d = IDLE;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 5'd1;
                        // Decrypt walks the schedule backwards, undoing the shift of the key just shown
                        if (dec_q) begin
                            rot_two = shift_two(5'd17 - round_q);
                            c_d     = ror_half(c_q, rot_two);
                            d_d     = ror_half(d_q, rot_two);
                        end else begin
                            rot_two = shift_two(round_q + 5'd1);
                            c_d     = rol_half(c_q, rot_two);
                            d_d     = rol_half(d_q, rot_two);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

endmodule
